// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared encodings, default sizes and PC slicing helpers for
//               the fetch-side branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int DEF_BTB_ENTRIES = 64;
    localparam int DEF_BHT_ENTRIES = 256;

    // Word index of the PC, masked to idx_bits; callers truncate to their width.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST)
                nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT)
                nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch lookup and EX-stage training bus of the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if;

    logic [31:0] PCF;
    logic        BTBF;
    logic        BHTF;
    logic [31:0] BTB_Target;

    logic        UpdE;
    logic [31:0] PCE;
    logic        BrTakenE;
    logic [31:0] BrTargetE;
    logic        BTBE;
    logic        BHTE;

    logic [31:0] BrCnt;
    logic [31:0] MissCnt;

    // Pipeline side: issues lookups and training, consumes predictions.
    modport master (
        output PCF, UpdE, PCE, BrTakenE, BrTargetE, BTBE, BHTE,
        input  BTBF, BHTF, BTB_Target, BrCnt, MissCnt
    );

    // Predictor side.
    modport slave (
        input  PCF, UpdE, PCE, BrTakenE, BrTargetE, BTBE, BHTE,
        output BTBF, BHTF, BTB_Target, BrCnt, MissCnt
    );

endinterface
`default_nettype wire

// File: rtl/branch_predictor_bht.sv
`default_nettype none
// ============================================================================
// Module      : bht_table
// Description : Flop-based array of 2-bit saturating counters with one
//               combinational read port and one update port.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_table
    import bp_pkg::*;
#(
    parameter int         ENTRIES = DEF_BHT_ENTRIES,
    parameter logic [1:0] INIT    = WNT,
    localparam int        IDX     = $clog2(ENTRIES)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic [IDX-1:0] i_rd_idx,
    output logic                o_rd_taken,
    input  wire logic           i_wr_en,
    input  wire logic [IDX-1:0] i_wr_idx,
    input  wire logic           i_wr_taken
);

    logic [1:0] r_cnt [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_cnt[i] <= INIT;
        end else if (i_wr_en) begin
            r_cnt[i_wr_idx] <= sat2_next(r_cnt[i_wr_idx], i_wr_taken);
        end
    end

    // Reads the pre-update value; a same-cycle write shows up next cycle.
    assign o_rd_taken = r_cnt[i_rd_idx][1];

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB plus 2-bit BHT with zero-latency lookup,
//               EX-stage training and branch/mispredict statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter int         BHT_ENTRIES = DEF_BHT_ENTRIES,
    parameter logic [1:0] BHT_INIT    = WNT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    branch_predictor_if.slave  bus
);

    localparam int BTB_IDX = $clog2(BTB_ENTRIES);
    localparam int BHT_IDX = $clog2(BHT_ENTRIES);
    localparam int TAG_W   = 30 - BTB_IDX;

    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag [BTB_ENTRIES];
    logic [31:0]            r_tgt [BTB_ENTRIES];
    logic [31:0]            r_brcnt;
    logic [31:0]            r_misscnt;

    logic [BTB_IDX-1:0] w_fbi;
    logic [TAG_W-1:0]   w_ftag;
    logic [BHT_IDX-1:0] w_fhi;
    logic [BTB_IDX-1:0] w_ebi;
    logic [TAG_W-1:0]   w_etag;
    logic [BHT_IDX-1:0] w_ehi;
    logic               w_btb_hit;
    logic               w_bht_taken;
    logic               w_btb_wr;
    logic               w_mispredict;

    assign w_fbi  = BTB_IDX'(pc_index(bus.PCF, BTB_IDX));
    assign w_ftag = TAG_W'(pc_tag(bus.PCF, BTB_IDX));
    assign w_fhi  = BHT_IDX'(pc_index(bus.PCF, BHT_IDX));
    assign w_ebi  = BTB_IDX'(pc_index(bus.PCE, BTB_IDX));
    assign w_etag = TAG_W'(pc_tag(bus.PCE, BTB_IDX));
    assign w_ehi  = BHT_IDX'(pc_index(bus.PCE, BHT_IDX));

    // Lookup reads flopped state only, so there is no update-to-lookup bypass.
    assign w_btb_hit      = r_valid[w_fbi] && (r_tag[w_fbi] == w_ftag);
    assign bus.BTBF       = w_btb_hit;
    assign bus.BTB_Target = w_btb_hit ? r_tgt[w_fbi] : 32'd0;
    assign bus.BHTF       = w_bht_taken;

    bht_table #(
        .ENTRIES (BHT_ENTRIES),
        .INIT    (BHT_INIT)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_fhi),
        .o_rd_taken (w_bht_taken),
        .i_wr_en    (bus.UpdE),
        .i_wr_idx   (w_ehi),
        .i_wr_taken (bus.BrTakenE)
    );

    // Only taken branches allocate; not-taken ones never evict an entry.
    assign w_btb_wr = bus.UpdE && bus.BrTakenE;

    always_ff @(posedge clk) begin
        if (rst)
            r_valid <= '0;
        else if (w_btb_wr)
            r_valid[w_ebi] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst && w_btb_wr) begin
            r_tag[w_ebi] <= w_etag;
            r_tgt[w_ebi] <= bus.BrTargetE;
        end
    end

    // The fetch-time prediction was "taken" only when both BTB and BHT agreed.
    assign w_mispredict = (bus.BTBE & bus.BHTE) != bus.BrTakenE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_brcnt   <= '0;
            r_misscnt <= '0;
        end else if (bus.UpdE) begin
            if (r_brcnt != c_cnt_max)
                r_brcnt <= r_brcnt + 32'd1;
            if (w_mispredict && (r_misscnt != c_cnt_max))
                r_misscnt <= r_misscnt + 32'd1;
        end
    end

    assign bus.BrCnt   = r_brcnt;
    assign bus.MissCnt = r_misscnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboarded bench for branch_predictor against a table model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    typedef struct {
        int          id;
        logic        btbf;
        logic        bhtf;
        logic [31:0] tgt;
        logic [31:0] br;
        logic [31:0] miss;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc_id;
    exp_t q[$];

    // Reference state: plain tables indexed by word address modulo size.
    bit          m_valid [64];
    longint      m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [256];
    longint      m_br;
    longint      m_miss;

    branch_predictor_if bus ();

    branch_predictor #(
        .BTB_ENTRIES (64),
        .BHT_ENTRIES (256),
        .BHT_INIT    (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 256; i++) m_cnt[i] = 1;
        m_br   = 0;
        m_miss = 0;
    endfunction

    task automatic cycle(input logic r, input logic upd, input logic [31:0] pcf,
                         input logic [31:0] pce, input logic tk, input logic [31:0] tgt,
                         input logic be, input logic he, input bit chk);
        exp_t e;
        int   bi;
        int   hi;
        rst           = r;
        bus.PCF       = pcf;
        bus.UpdE      = upd;
        bus.PCE       = pce;
        bus.BrTakenE  = tk;
        bus.BrTargetE = tgt;
        bus.BTBE      = be;
        bus.BHTE      = he;
        if (chk) begin
            bi     = int'((pcf / 4) % 64);
            hi     = int'((pcf / 4) % 256);
            e.id   = cyc_id;
            e.btbf = m_valid[bi] && (m_tag[bi] == longint'(pcf / 256));
            e.tgt  = e.btbf ? m_tgt[bi] : 32'd0;
            e.bhtf = m_cnt[hi] >= 2;
            e.br   = m_br[31:0];
            e.miss = m_miss[31:0];
            q.push_back(e);
        end
        if (r) begin
            model_reset();
        end else if (upd) begin
            bi = int'((pce / 4) % 64);
            hi = int'((pce / 4) % 256);
            if (tk) begin
                m_valid[bi] = 1'b1;
                m_tag[bi]   = longint'(pce / 256);
                m_tgt[bi]   = tgt;
                if (m_cnt[hi] < 3) m_cnt[hi]++;
            end else begin
                if (m_cnt[hi] > 0) m_cnt[hi]--;
            end
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (((be & he) != tk) && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", nm, id, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("BTBF",       e.id, {31'd0, bus.BTBF}, {31'd0, e.btbf});
                cmp("BHTF",       e.id, {31'd0, bus.BHTF}, {31'd0, e.bhtf});
                cmp("BTB_Target", e.id, bus.BTB_Target, e.tgt);
                cmp("BrCnt",      e.id, bus.BrCnt, e.br);
                cmp("MissCnt",    e.id, bus.MissCnt, e.miss);
            end
        end
    end

    initial begin : stimulus
        logic [31:0] pf;
        logic [31:0] pe;
        checks = 0;
        errors = 0;
        cyc_id = 0;
        for (int i = 0; i < 64; i++) begin
            m_tag[i] = 0;
            m_tgt[i] = 32'd0;
        end
        rst = 1'b1;
        bus.PCF = 32'd0; bus.UpdE = 1'b0; bus.PCE = 32'd0; bus.BrTakenE = 1'b0;
        bus.BrTargetE = 32'd0; bus.BTBE = 1'b0; bus.BHTE = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset state
        cycle(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Train 0x100 taken twice, then look it up
        repeat (2) cycle(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Alias in BTB slot 0 with a different tag
        cycle(1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Walk the counter down past SNT, then one taken
        repeat (5) cycle(1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Same-cycle lookup and update: no bypass
        cycle(1'b0, 1'b1, 32'h300, 32'h300, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        // Reset dominates a simultaneous update
        cycle(1'b1, 1'b1, 32'h100, 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Random traffic over a small PC window so aliasing and hits are common
        for (int n = 0; n < 600; n++) begin
            pf = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            pe = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2);
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), pf, pe,
                  1'($urandom), {$urandom_range(0, 255), 2'b00}, 1'($urandom), 1'($urandom), 1'b1);
        end

        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        cmp("scoreboard_drain", cyc_id, q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
